// File: rtl/wb_master_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_master_pkg
//  Description : Shared constants and types for the Wishbone B4 classic-cycle
//                master request engine (cycle-type / burst-type encodings and
//                the engine state enumeration).
//  Revision    : 1.0 - initial release
// ============================================================================
package wb_master_pkg;

    // Wishbone cycle type identifiers
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    // Wishbone burst type extensions
    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;
    localparam logic [1:0] BTE_WRAP16  = 2'b11;

    // Engine states: waiting for a request, or owning the bus
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

endpackage
`default_nettype wire

// File: rtl/wb_master_timeout.sv
`default_nettype none
// ============================================================================
//  Module      : wb_master_timeout
//  Description : Bus-cycle watchdog. Counts clocks while the engine is ACTIVE
//                and flags expiry on the TIMEOUT_CYCLES-th active clock.
//                Counter is cleared whenever the engine is not active.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_master_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic active_i,
    output logic expired_o
);

    // Counter only has to reach TIMEOUT_CYCLES-1, so clog2 bits suffice
    localparam int unsigned         c_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0]  c_LAST  = c_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [c_CNT_W-1:0] cnt_q;
    logic [c_CNT_W-1:0] cnt_d;

    // Expiry fires on the active clock whose edge completes the limit
    assign expired_o = active_i && (cnt_q == c_LAST);

    // Next count: restart on idle or on expiry, otherwise advance
    always_comb begin
        cnt_d = cnt_q + c_CNT_W'(1);
        if (!active_i || expired_o) begin
            cnt_d = '0;
        end
    end

    // Watchdog counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_master_req_core.sv
`default_nettype none
// ============================================================================
//  Module      : wb_master_req_core
//  Description : Wishbone B4 classic-cycle master engine. Accepts one
//                single-beat request at a time, registers it straight onto
//                the bus, and returns a one-cycle response (error flag and
//                read data) when the slave terminates the cycle.
//                Optional watchdog: define WB_MASTER_TIMEOUT_EN to end a
//                cycle with an error after TIMEOUT_CYCLES silent clocks.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_master_req_core
    import wb_master_pkg::*;
#(
    parameter int unsigned WB_ADDR_WIDTH  = 32,
    parameter int unsigned WB_DATA_WIDTH  = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    // Local request / response port
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [WB_ADDR_WIDTH-1:0]   req_adr,
    input  logic [2:0]                 req_cti,
    input  logic [1:0]                 req_bte,
    input  logic [WB_DATA_WIDTH/8-1:0] req_sel,
    input  logic                       req_we,
    input  logic [WB_DATA_WIDTH-1:0]   req_wdata,
    output logic                       rsp_valid,
    output logic                       rsp_err,
    output logic [WB_DATA_WIDTH-1:0]   rsp_rdata,
    output logic                       reset_done,
    // Wishbone master port
    output logic [WB_ADDR_WIDTH-1:0]   ADR,
    output logic [2:0]                 CTI,
    output logic [1:0]                 BTE,
    output logic [WB_DATA_WIDTH-1:0]   DAT_W,
    output logic [WB_DATA_WIDTH/8-1:0] SEL,
    output logic                       CYC,
    output logic                       STB,
    output logic                       WE,
    input  logic [WB_DATA_WIDTH-1:0]   DAT_R,
    input  logic                       ACK,
    input  logic                       ERR
);

    localparam int unsigned c_SEL_W = WB_DATA_WIDTH / 8;

    // Elaboration-time sanity checks on the configuration
    if ((WB_DATA_WIDTH % 8) != 0) begin : g_bad_data_width
        $error("wb_master_req_core: WB_DATA_WIDTH must be a multiple of 8");
    end
    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("wb_master_req_core: TIMEOUT_CYCLES must be non-zero");
    end

    state_e                     state_q, state_d;
    logic [WB_ADDR_WIDTH-1:0]   adr_q,   adr_d;
    logic [2:0]                 cti_q,   cti_d;
    logic [1:0]                 bte_q,   bte_d;
    logic [WB_DATA_WIDTH-1:0]   datw_q,  datw_d;
    logic [c_SEL_W-1:0]         sel_q,   sel_d;
    logic                       cyc_q,   cyc_d;
    logic                       we_q,    we_d;
    logic                       rsp_valid_q, rsp_valid_d;
    logic                       rsp_err_q,   rsp_err_d;
    logic [WB_DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                       reset_pend_q;
    logic                       reset_done_q;

    logic                       w_timeout;
    logic                       w_done;

`ifdef WB_MASTER_TIMEOUT_EN
    wb_master_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .active_i  (state_q == ACTIVE),
        .expired_o (w_timeout)
    );
`else
    assign w_timeout = 1'b0;
`endif

    // The cycle ends on ACK, ERR or watchdog expiry (only meaningful while ACTIVE)
    assign w_done = ACK | ERR | w_timeout;

    // Next-state and bus/response datapath
    always_comb begin
        state_d     = state_q;
        adr_d       = adr_q;
        cti_d       = cti_q;
        bte_d       = bte_q;
        datw_d      = datw_q;
        sel_d       = sel_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = rsp_rdata_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    adr_d   = req_adr;
                    cti_d   = req_cti;
                    bte_d   = req_bte;
                    sel_d   = req_sel;
                    we_d    = req_we;
                    datw_d  = req_we ? req_wdata : '0;
                    cyc_d   = 1'b1;
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (w_done) begin
                    adr_d       = '0;
                    cti_d       = '0;
                    bte_d       = '0;
                    sel_d       = '0;
                    we_d        = 1'b0;
                    datw_d      = '0;
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    // Anything other than a clean ACK (ERR, ACK+ERR, timeout) is an error
                    rsp_err_d   = ERR | ~ACK;
                    if (!we_q && ACK && !ERR) begin
                        rsp_rdata_d = DAT_R;
                    end
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Engine state, bus and response registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            adr_q       <= '0;
            cti_q       <= '0;
            bte_q       <= '0;
            datw_q      <= '0;
            sel_q       <= '0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            adr_q       <= adr_d;
            cti_q       <= cti_d;
            bte_q       <= bte_d;
            datw_q      <= datw_d;
            sel_q       <= sel_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Reset-release pulse: the pending flag is armed by reset and consumed on the first clock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reset_pend_q <= 1'b1;
            reset_done_q <= 1'b0;
        end else begin
            reset_pend_q <= 1'b0;
            reset_done_q <= reset_pend_q;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign rsp_valid  = rsp_valid_q;
    assign rsp_err    = rsp_err_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign reset_done = reset_done_q;

    // STB mirrors CYC for single-beat classic cycles
    assign ADR   = adr_q;
    assign CTI   = cti_q;
    assign BTE   = bte_q;
    assign DAT_W = datw_q;
    assign SEL   = sel_q;
    assign CYC   = cyc_q;
    assign STB   = cyc_q;
    assign WE    = we_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_master_req_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_master_req_core
//  Description : Self-checking bench for wb_master_req_core. A transaction-
//                level reference model tracks the outstanding request and
//                predicts every output each cycle; directed steps add literal
//                expectations for the key scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_wb_master_req_core;

    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int SW     = DW / 8;
    localparam int TO_CYC = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_adr;
    logic [2:0]    req_cti;
    logic [1:0]    req_bte;
    logic [SW-1:0] req_sel;
    logic          req_we;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic          reset_done;
    logic [AW-1:0] ADR;
    logic [2:0]    CTI;
    logic [1:0]    BTE;
    logic [DW-1:0] DAT_W;
    logic [SW-1:0] SEL;
    logic          CYC;
    logic          STB;
    logic          WE;
    logic [DW-1:0] DAT_R;
    logic          ACK;
    logic          ERR;

    int n_tests = 0;
    int n_fail  = 0;

    wb_master_req_core #(
        .WB_ADDR_WIDTH  (AW),
        .WB_DATA_WIDTH  (DW),
        .TIMEOUT_CYCLES (TO_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_adr    (req_adr),
        .req_cti    (req_cti),
        .req_bte    (req_bte),
        .req_sel    (req_sel),
        .req_we     (req_we),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_err    (rsp_err),
        .rsp_rdata  (rsp_rdata),
        .reset_done (reset_done),
        .ADR        (ADR),
        .CTI        (CTI),
        .BTE        (BTE),
        .DAT_W      (DAT_W),
        .SEL        (SEL),
        .CYC        (CYC),
        .STB        (STB),
        .WE         (WE),
        .DAT_R      (DAT_R),
        .ACK        (ACK),
        .ERR        (ERR)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    // One outstanding transaction (or none); bus shows it while outstanding.
    logic          m_busy, m_we, m_first, m_rv, m_re, m_rdone;
    logic [AW-1:0] m_adr;
    logic [2:0]    m_cti;
    logic [1:0]    m_bte;
    logic [SW-1:0] m_sel;
    logic [DW-1:0] m_wdata, m_rdata;
    int            m_age;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 0; m_we = 0; m_first = 1; m_rv = 0; m_re = 0; m_rdone = 0;
            m_adr = 0; m_cti = 0; m_bte = 0; m_sel = 0; m_wdata = 0; m_rdata = 0; m_age = 0;
        end else begin
            logic to;
            m_rdone = m_first;
            m_first = 0;
            m_rv    = 0;
            m_re    = 0;
            if (!m_busy) begin
                if (req_valid) begin
                    m_busy = 1; m_adr = req_adr; m_cti = req_cti; m_bte = req_bte;
                    m_sel = req_sel; m_we = req_we; m_wdata = req_wdata; m_age = 0;
                end
            end else begin
                m_age++;
`ifdef WB_MASTER_TIMEOUT_EN
                to = (m_age >= TO_CYC);
`else
                to = 1'b0;
`endif
                if (ACK || ERR || to) begin
                    m_busy = 0;
                    m_rv   = 1;
                    m_re   = ERR || !ACK;
                    if (ACK && !ERR && !m_we) m_rdata = DAT_R;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        chk("CYC",        CYC,        m_busy);
        chk("STB",        STB,        m_busy);
        chk("WE",         WE,         m_busy & m_we);
        chk("ADR",        ADR,        m_busy ? m_adr : '0);
        chk("CTI",        CTI,        m_busy ? m_cti : '0);
        chk("BTE",        BTE,        m_busy ? m_bte : '0);
        chk("SEL",        SEL,        m_busy ? m_sel : '0);
        chk("DAT_W",      DAT_W,      (m_busy && m_we) ? m_wdata : '0);
        chk("req_ready",  req_ready,  !m_busy);
        chk("rsp_valid",  rsp_valid,  m_rv);
        chk("rsp_err",    rsp_err,    m_re);
        chk("rsp_rdata",  rsp_rdata,  m_rdata);
        chk("reset_done", reset_done, m_rdone);
    end

    // ---------------- directed stimulus ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [AW-1:0] a, input logic we, input logic [DW-1:0] wd,
                           input logic [SW-1:0] s, input logic [2:0] c, input logic [1:0] b);
        req_adr = a; req_we = we; req_wdata = wd; req_sel = s; req_cti = c; req_bte = b;
        req_valid = 1'b1;
    endtask

    initial begin
        int cnt;
        int k;
        logic seen;
        rst = 1'b1; req_valid = 0; req_adr = 0; req_cti = 0; req_bte = 0; req_sel = 0;
        req_we = 0; req_wdata = 0; DAT_R = 0; ACK = 0; ERR = 0;

        // Reset and release pulse
        repeat (3) tick;
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_cyc", CYC, 1'b0);
        rst = 1'b0;
        tick;
        chk("reset_done_pulse", reset_done, 1'b1);
        tick;
        chk("reset_done_once", reset_done, 1'b0);

        // Write, ACK two cycles after acceptance
        set_req(32'h1000, 1'b1, 32'hDEADBEEF, 4'hF, 3'b000, 2'b00);
        tick;
        req_valid = 0;
        chk("wr_cyc", CYC, 1'b1);
        chk("wr_we", WE, 1'b1);
        chk("wr_adr", ADR, 32'h1000);
        chk("wr_datw", DAT_W, 32'hDEADBEEF);
        chk("wr_ready_low", req_ready, 1'b0);
        tick;
        chk("wr_hold_cyc", CYC, 1'b1);
        ACK = 1;
        tick;
        ACK = 0;
        chk("wr_rsp_valid", rsp_valid, 1'b1);
        chk("wr_rsp_err", rsp_err, 1'b0);
        chk("wr_bus_clear", {CYC, STB, WE, DAT_W}, '0);
        tick;
        chk("wr_rsp_one_cycle", rsp_valid, 1'b0);

        // Read: write data masked to zero, read data captured
        set_req(32'h2004, 1'b0, 32'hFFFFFFFF, 4'hF, 3'b111, 2'b01);
        tick;
        req_valid = 0;
        chk("rd_datw_zero", DAT_W, 32'h0);
        chk("rd_cti_bte", {CTI, BTE}, {3'b111, 2'b01});
        DAT_R = 32'h12345678; ACK = 1;
        tick;
        ACK = 0; DAT_R = 0;
        chk("rd_rsp_valid", rsp_valid, 1'b1);
        chk("rd_rdata", rsp_rdata, 32'h12345678);

        // Following write leaves read data untouched
        set_req(32'h1004, 1'b1, 32'hCAFEF00D, 4'h3, 3'b000, 2'b00);
        tick;
        req_valid = 0;
        DAT_R = 32'h55555555; ACK = 1;
        tick;
        ACK = 0; DAT_R = 0;
        chk("wr_keeps_rdata", rsp_rdata, 32'h12345678);

        // Errored read
        tick;
        set_req(32'h2008, 1'b0, 32'h0, 4'hF, 3'b000, 2'b00);
        tick;
        req_valid = 0;
        DAT_R = 32'hAAAAAAAA; ERR = 1;
        tick;
        ERR = 0; DAT_R = 0;
        chk("err_rsp_valid", rsp_valid, 1'b1);
        chk("err_rsp_err", rsp_err, 1'b1);
        chk("err_keeps_rdata", rsp_rdata, 32'h12345678);

        // Stray ACK while idle
        tick;
        ACK = 1; DAT_R = 32'h99999999;
        tick;
        ACK = 0; DAT_R = 0;
        chk("stray_ack_no_rsp", rsp_valid, 1'b0);

        // ACK and ERR together count as error
        set_req(32'h200C, 1'b0, 32'h0, 4'hF, 3'b000, 2'b00);
        tick;
        req_valid = 0;
        ACK = 1; ERR = 1; DAT_R = 32'h0BADF00D;
        tick;
        ACK = 0; ERR = 0; DAT_R = 0;
        chk("ackerr_rsp_err", rsp_err, 1'b1);
        chk("ackerr_keeps_rdata", rsp_rdata, 32'h12345678);

        // Back-to-back: req_valid held, slave ACKs every bus cycle immediately
        tick;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            ACK       = CYC;
            req_valid = (i < 5);
            req_adr   = 32'h3000 + 32'(i * 4);
            req_we    = 1'b1;
            req_wdata = 32'hB0B0_0000 + 32'(i);
            tick;
            if (rsp_valid) cnt++;
        end
        ACK = 0; req_valid = 0;
        chk("b2b_rsp_count", cnt, 3);

        // Unresponsive slave
        tick;
        set_req(32'h4000, 1'b0, 32'h0, 4'hF, 3'b000, 2'b00);
        tick;
        req_valid = 0;
`ifdef WB_MASTER_TIMEOUT_EN
        k = 0; seen = 0;
        while (!seen && k < 20) begin
            k++;
            tick;
            if (rsp_valid) seen = 1;
        end
        chk("timeout_latency", k, TO_CYC);
        chk("timeout_rsp_err", rsp_err, 1'b1);
        chk("timeout_keeps_rdata", rsp_rdata, 32'h12345678);
`else
        k = 0; seen = 0;
        repeat (20) tick;
        chk("no_timeout_cyc_held", CYC, 1'b1);
        ACK = 1;
        tick;
        ACK = 0;
        chk("late_ack_rsp", rsp_valid, 1'b1);
        chk("late_ack_rdata", rsp_rdata, 32'h0);
`endif

        // Reset asserted mid-cycle
        tick;
        set_req(32'h5000, 1'b1, 32'h11112222, 4'hF, 3'b000, 2'b00);
        tick;
        req_valid = 0;
        chk("mid_cyc_active", CYC, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_cyc_drop", CYC, 1'b0);
        chk("mid_rst_stb_drop", STB, 1'b0);
        tick;
        chk("mid_rst_no_rsp", rsp_valid, 1'b0);
        tick;
        // Release reset and offer a request in the very first cycle
        rst = 1'b0;
        set_req(32'h6000, 1'b0, 32'h0, 4'hF, 3'b000, 2'b00);
        tick;
        req_valid = 0;
        chk("rel_reset_done", reset_done, 1'b1);
        chk("rel_accept_cyc", CYC, 1'b1);
        chk("rel_no_rsp", rsp_valid, 1'b0);
        DAT_R = 32'h600DCAFE; ACK = 1;
        tick;
        ACK = 0; DAT_R = 0;
        chk("rel_rd_rdata", rsp_rdata, 32'h600DCAFE);
        tick;
        tick;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard bound on total run time
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "bench watchdog expired");
    end

endmodule
`default_nettype wire
